// File: rtl/hyperbus_arb_pkg.sv
// Shared types and helpers for the Hyperbus PHY transaction arbiter.
//   hyper_arb_state_e : arbiter FSM states (Arb, Req, Busy)
//   onehot_from_idx   : index to one-hot decode, MaxPorts wide; callers truncate
package hyperbus_arb_pkg;

    localparam int unsigned MaxPorts = 32;
    localparam int unsigned IdxW     = 5;

    typedef enum logic [1:0] {
        Arb  = 2'd0,
        Req  = 2'd1,
        Busy = 2'd2
    } hyper_arb_state_e;

    function automatic logic [MaxPorts-1:0] onehot_from_idx(input logic [IdxW-1:0] idx);
        logic [MaxPorts-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/hyperbus_rr_pick.sv
// Combinational masked priority encoder for the Hyperbus arbiter.
//   valid_i     : per-port request valid
//   last_i      : previous owner; search starts at last_i+1 (round-robin only)
//   winner_c    : index of the selected port (0 when nothing is valid)
//   any_valid_c : at least one port is requesting
module hyperbus_rr_pick #(
    parameter int unsigned NumPorts   = 2,
    parameter bit          RoundRobin = 1'b1,
    parameter int unsigned SelW       = $clog2(NumPorts)
) (
    input  logic [NumPorts-1:0] valid_i,
    input  logic [SelW-1:0]     last_i,
    output logic [SelW-1:0]     winner_c,
    output logic                any_valid_c
);

    logic [31:0]     base;
    logic [31:0]     idx;
    logic [SelW-1:0] cand;

    // Fixed priority is a round-robin search anchored at NumPorts-1, so the
    // scan starts at port 0. Scanning from the far end lets the nearest valid
    // candidate overwrite earlier ones.
    always_comb begin
        winner_c    = '0;
        any_valid_c = |valid_i;
        base        = RoundRobin ? 32'(last_i) : 32'(NumPorts - 1);
        idx         = '0;
        cand        = '0;
        for (int off = int'(NumPorts); off > 0; off--) begin
            idx  = (base + 32'(off)) % NumPorts;
            cand = SelW'(idx);
            if (valid_i[cand]) begin
                winner_c = cand;
            end
        end
    end

endmodule

// File: rtl/hyperbus_phy_arbiter.sv
// N-port arbiter for the Hyperbus PHY transaction channel.
//   clk_i, rst_i        : clock, synchronous active-high reset
//   trans_valid_i       : per-port transaction request
//   phy_trans_ready_i   : PHY accepts the selected transaction
//   phy_rx_* / phy_tx_* : PHY data handshakes; a last beat ends a transaction
//   sel_o               : port muxed onto the PHY
//   gnt_o               : one-hot grant, zero while arbitrating
//   busy_o              : a transaction is in flight
module hyperbus_phy_arbiter
    import hyperbus_arb_pkg::*;
#(
    parameter int unsigned NumPorts   = 2,
    parameter bit          RoundRobin = 1'b1,
    parameter int unsigned MaxChain   = 4,
    parameter int unsigned SelW       = $clog2(NumPorts)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumPorts-1:0] trans_valid_i,
    input  logic                phy_trans_ready_i,
    input  logic                phy_rx_valid_i,
    input  logic                phy_rx_ready_i,
    input  logic                phy_rx_last_i,
    input  logic                phy_tx_valid_i,
    input  logic                phy_tx_ready_i,
    input  logic                phy_tx_last_i,
    output logic [SelW-1:0]     sel_o,
    output logic [NumPorts-1:0] gnt_o,
    output logic                busy_o
);

    localparam int unsigned ChainW = $clog2(MaxChain + 1);

    hyper_arb_state_e    state_q;
    logic [SelW-1:0]     sel_q;
    logic [SelW-1:0]     last_q;
    logic [ChainW-1:0]   chain_q;
    logic [NumPorts-1:0] gnt_q;
    logic                busy_q;

    logic [SelW-1:0]     winner;
    logic                any_valid;
    logic                acc;
    logic                xfer_end;

    hyperbus_rr_pick #(
        .NumPorts  (NumPorts),
        .RoundRobin(RoundRobin),
        .SelW      (SelW)
    ) u_pick (
        .valid_i    (trans_valid_i),
        .last_i     (last_q),
        .winner_c   (winner),
        .any_valid_c(any_valid)
    );

    assign acc      = trans_valid_i[sel_q] & phy_trans_ready_i;
    // Simultaneous RX and TX last beats collapse into one end event.
    assign xfer_end = (phy_rx_valid_i & phy_rx_ready_i & phy_rx_last_i)
                    | (phy_tx_valid_i & phy_tx_ready_i & phy_tx_last_i);

    // Arbitration FSM; grant and busy are registered alongside the state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= Arb;
            sel_q   <= '0;
            last_q  <= SelW'(NumPorts - 1);
            chain_q <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                Arb: begin
                    if (any_valid) begin
                        state_q <= Req;
                        sel_q   <= winner;
                        chain_q <= '0;
                        gnt_q   <= NumPorts'(onehot_from_idx(IdxW'(winner)));
                    end
                end
                Req: begin
                    if (acc) begin
                        state_q <= Busy;
                        chain_q <= ChainW'(1);
                        busy_q  <= 1'b1;
                    end else if (!trans_valid_i[sel_q]) begin
                        // Withdrawal leaves last_q alone so the owner order is kept.
                        state_q <= Arb;
                        gnt_q   <= '0;
                    end
                end
                Busy: begin
                    if (xfer_end) begin
                        if (acc && (chain_q < ChainW'(MaxChain))) begin
                            chain_q <= chain_q + ChainW'(1);
                        end else begin
                            state_q <= Arb;
                            last_q  <= sel_q;
                            gnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= Arb;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sel_o  = sel_q;
    assign gnt_o  = gnt_q;
    assign busy_o = busy_q;

endmodule
